// File: rtl/pipe_reg_bank.sv
// pipe_reg_bank: DEPTH-stage valid/ready register bank moving NUM_CH x WIDTH beats with bubble collapsing.
// Optional macro PIPE_REG_OCC_EN adds the occupancy output and its counter.
module pipe_reg_bank #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*WIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_CH*WIDTH-1:0]   out_data
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    localparam int unsigned DW = NUM_CH * WIDTH;

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [DW-1:0]    data_q [DEPTH];
    logic             in_xfer;

    // A stage may load when some stage at or beyond it is empty, or the consumer is draining.
    function automatic logic stage_rdy(input int unsigned idx,
                                       input logic [DEPTH-1:0] vv,
                                       input logic ordy);
        logic r;
        r = ordy;
        for (int unsigned j = idx; j < DEPTH; j++) begin
            r = r | ~vv[j];
        end
        return r;
    endfunction

    always_comb begin
        rdy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy[i] = stage_rdy(i, v, out_ready);
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    // Stage shift: data registers only load from a valid source, bubbles just move the valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= in_xfer;
                if (in_xfer) begin
                    data_q[0] <= in_data;
                end
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end
    end

`ifdef PIPE_REG_OCC_EN
    localparam int unsigned OW = $clog2(DEPTH + 1);

    logic          out_xfer;
    logic [OW-1:0] occ_q;

    assign out_xfer = out_valid & out_ready;

    // Beat count tracks transfers; internal bubble movement never changes it.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OW'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_q <= occ_q - OW'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_bank.sv
// Bench for pipe_reg_bank: DEPTH=1 and DEPTH=3 instances, directed plus random traffic vs a slot-position model.
`timescale 1ns/1ps
module tb_pipe_reg_bank;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DW     = WIDTH * NUM_CH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    bit done0 = 1'b0;
    bit done1 = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        int            pos;
    } beat_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    for (genvar gj = 0; gj < 2; gj++) begin : g
        localparam int D = (gj == 0) ? 1 : 3;

        logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
        logic [DW-1:0] in_data, out_data;
`ifdef PIPE_REG_OCC_EN
        logic [$clog2(D+1)-1:0] occupancy;
`endif

        pipe_reg_bank #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(D)) dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
`ifdef PIPE_REG_OCC_EN
            ,
            .occupancy (occupancy)
`endif
        );

        task automatic drive(input logic r, input logic f, input logic iv,
                             input logic [DW-1:0] d, input logic o);
            reset = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
            @(posedge clk);
            #1;
        endtask

        // Stimulus: test-plan scenarios, then random traffic.
        initial begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
            drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
            if (D == 1) begin
                drive(1'b0, 1'b0, 1'b1, {32'hDEADBEEF, 32'h00000005}, 1'b1);
                drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
            end else begin
                for (int k = 1; k <= 3; k++) drive(1'b0, 1'b0, 1'b1, DW'(k), 1'b1);
                repeat (4) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
                for (int k = 1; k <= 4; k++) drive(1'b0, 1'b0, 1'b1, DW'(k), 1'b0);
                drive(1'b0, 1'b0, 1'b1, DW'(4), 1'b0);
                drive(1'b0, 1'b0, 1'b1, DW'(4), 1'b1);
                repeat (5) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
                drive(1'b0, 1'b0, 1'b1, DW'(5), 1'b0);
                drive(1'b0, 1'b0, 1'b1, DW'(6), 1'b0);
                drive(1'b0, 1'b1, 1'b1, DW'(7), 1'b0);
                drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
                for (int k = 8; k <= 10; k++) drive(1'b0, 1'b0, 1'b1, DW'(k), 1'b0);
                drive(1'b1, 1'b0, 1'b1, DW'(99), 1'b0);
                drive(1'b0, 1'b0, 1'b1, DW'(32'h12345678), 1'b1);
                repeat (4) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
            end
            repeat (600) begin
                drive($urandom_range(63) == 0, $urandom_range(15) == 0,
                      $urandom_range(9) < 7, {$urandom, $urandom}, $urandom_range(9) < 6);
            end
            repeat (D + 2) drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
            if (gj == 0) done0 = 1'b1;
            else         done1 = 1'b1;
        end

        // Model: beats in arrival order, each at a slot 0..D-1; a beat advances if the slot ahead is free.
        beat_t         beats [$];
        logic [DW-1:0] last_out;
        bit            armed = 1'b0;

        always @(negedge clk) begin
            int            cnt;
            int            limit;
            logic          exp_ir, exp_ov, in_x;
            logic [DW-1:0] exp_od;
            beat_t         b;

            cnt    = beats.size();
            exp_ir = !flush && (cnt < D || out_ready);
            exp_ov = (cnt > 0) && (beats[0].pos == D - 1);
            exp_od = exp_ov ? beats[0].data : last_out;

            if (armed) begin
                check($sformatf("d%0d in_ready", D),  DW'(in_ready),  DW'(exp_ir));
                check($sformatf("d%0d out_valid", D), DW'(out_valid), DW'(exp_ov));
                check($sformatf("d%0d out_data", D),  out_data,       exp_od);
`ifdef PIPE_REG_OCC_EN
                check($sformatf("d%0d occupancy", D), DW'(occupancy), DW'(cnt));
`endif
            end

            if (reset) begin
                beats.delete();
                last_out = '0;
                armed    = 1'b1;
            end else if (armed) begin
                in_x = in_valid && exp_ir;
                if (out_valid && out_ready) begin
                    if (beats.size() == 0) begin
                        check($sformatf("d%0d spurious beat", D), out_data, 'x);
                    end else begin
                        b = beats.pop_front();
                        check($sformatf("d%0d delivered beat", D), out_data, b.data);
                    end
                end
                if (flush) begin
                    beats.delete();
                end else begin
                    limit = D;
                    foreach (beats[k]) begin
                        if (beats[k].pos + 1 < limit) begin
                            beats[k].pos++;
                            if (beats[k].pos == D - 1) last_out = beats[k].data;
                        end
                        limit = beats[k].pos;
                    end
                    if (in_x) begin
                        b.data = in_data;
                        b.pos  = 0;
                        beats.push_back(b);
                        if (D == 1) last_out = in_data;
                    end
                end
            end
        end
    end

    initial begin
        for (int t = 0; t < 20000 && !(done0 && done1); t++) @(posedge clk);
        if (!(done0 && done1)) begin
            checks++;
            $display("FAIL timeout: stimulus done=%0b%0b required 11", done1, done0);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_bank.md
Name: pipe_reg_bank

Overview:
- Parametrised multi-channel pipeline register bank for the multicycle MIPS datapath.
- Successor to the fixed two-channel, 32-bit operand latch: generalised in channel count, data width and pipeline depth.
- Adds a valid/ready handshake, stall, flush and bubble collapsing.
- Sits between the register file read ports and the ALU operand muxes; also usable as a generic staged operand buffer.

Parameters:
- WIDTH, 32, bits per channel.
- NUM_CH, 2, number of parallel channels carried together as one beat.
- DEPTH, 1, number of register stages (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all stored beats at the next edge.
- in_valid  input  1  in_data holds a beat.
- in_ready  output  1  bank accepts a beat this cycle.
- in_data  input  NUM_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]; channel 0 at the LSBs.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  consumer takes the beat this cycle.
- out_data  output  NUM_CH*WIDTH  same packing as in_data.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages; present only with PIPE_REG_OCC_EN.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Storage: stages 0..DEPTH-1, each holding a data register (NUM_CH*WIDTH bits) and a valid bit v[i].
  - Stage 0 is the input stage; stage DEPTH-1 drives out_data and out_valid (out_valid = v[DEPTH-1]).
- Reset: all v[i]=0 and all data registers=0.
  - Immediately after reset: out_valid=0, out_data=0, occupancy=0, in_ready=1.
  - Reset has priority over flush and over every handshake.
- Ready chain (combinational):
  - rdy[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0] & !flush.
- Stage load, in priority order:
  - Stage i (i>0) loads from stage i-1 when rdy[i] is high: v[i] <= v[i-1], and data is copied only if v[i-1]=1.
  - Stage 0 loads from the input when rdy[0] is high: v[0] <= in_valid & in_ready.
  - A stage whose rdy is low holds both data and valid.
- Data registers update only on a valid load. A bubble moving forward clears v but leaves the data register unchanged.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Latency and throughput:
  - An accepted beat appears on out_data exactly DEPTH cycles later if downstream never stalls.
  - Sustained throughput is 1 beat/cycle.
- Stall: while out_valid=1 and out_ready=0, out_data is held bit-stable.
  - Upstream bubbles collapse: each empty stage still accepts a beat.
  - in_ready falls only when all DEPTH stages are valid and out_ready=0.
- Full with out_ready=1: a simultaneous input and output transfer is permitted; occupancy is unchanged.
- Flush: at the next edge all v[i]=0 and data registers are unchanged.
  - in_ready=0 during the flush cycle, so no beat is accepted.
  - An output transfer in the flush cycle still counts as delivered.
- DEPTH=1 degenerates to a single valid-gated register with the same rules.
- Reset asserted mid-stream drops all in-flight beats. The first accepted beat after reset deasserts appears after DEPTH cycles.
- No X propagation: data registers are never loaded from an invalid source.

Optional Feature:
- Macro: PIPE_REG_OCC_EN.
- Defined:
  - occupancy port exists and equals the count of set v[i].
  - Reset and flush set it to 0 at the edge.
  - It increments on an input transfer alone, decrements on an output transfer alone, and is unchanged on both or neither.
  - Range is 0..DEPTH.
- Undefined: occupancy port and its counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then pass-through, DEPTH=1: reset=1 for 2 cycles gives out_valid=0, out_data=0, in_ready=1. Then in_data={32'hDEADBEEF,32'h00000005} with in_valid=1 and out_ready=1 gives out_data equal to that value one cycle later, with out_valid=1.
- Latency, DEPTH=3: present beats 1,2,3 on consecutive cycles with out_ready=1. out_valid rises 3 cycles after the first accept and the beats emerge as 1,2,3 back-to-back.
- Stall and fill, DEPTH=3:
  - Hold out_ready=0 and offer 4 beats. in_ready drops after the 3rd accept; out_data holds beat 1 stable; occupancy=3 (with PIPE_REG_OCC_EN).
  - Raise out_ready: beats 1,2,3,4 emerge in order with no loss.
- Full simultaneous transfer: full bank (3 beats), in_valid=1 and out_ready=1 for 1 cycle. Beat 1 leaves, beat 4 enters, occupancy stays 3.
- Flush: 2 beats in flight, assert flush with in_valid=1. Next cycle out_valid=0 and occupancy=0, and the offered beat is not accepted (in_ready=0 in that cycle).
- Reset mid-operation: assert reset while full and stalled. Next edge all valids=0 and out_data=0. A beat 32'h12345678 accepted after reset appears DEPTH cycles later.
